// File: rtl/lut_k_frac_cfg_if.sv
// Configuration-chain port bundle for the K-input fracturable LUT element.
//
// Handshake: the chain has no backpressure. CONFin is accepted on a rising
// UserCLK edge exactly when MODE=1 and CONFvalid=1. CONFout is the shadow
// MSB. CONFdone is high for one cycle after a commit. CONFerr is sticky
// until the next good commit. cfg_state shows the control state
// (0 = IDLE, 1 = SHIFT) so that checkers can observe it.
interface lut_k_frac_cfg_if;
   logic MODE;
   logic CONFin;
   logic CONFvalid;
   logic CONFout;
   logic CONFdone;
   logic CONFerr;
   logic cfg_state;

   modport master (
      output MODE, CONFin, CONFvalid,
      input  CONFout, CONFdone, CONFerr, cfg_state
   );

   modport slave (
      input  MODE, CONFin, CONFvalid,
      output CONFout, CONFdone, CONFerr, cfg_state
   );
endinterface

// File: rtl/lut_k_frac_cfg.sv
// K-input LUT logic element. It has a fracturable dual output, a registered
// output with CE and synchronous set/reset, and a double-buffered serial
// configuration chain. The shadow register shifts while MODE=1. It is
// committed to the active frame on MODE falling, but only if a full frame
// was shifted in.
module lut_k_frac_cfg #(
   parameter int LUT_SIZE = 4
) (
   input  logic                UserCLK,
   input  logic                RSTn,
   input  logic [LUT_SIZE-1:0] I,
   input  logic                Ci,
   output logic                Co,
   output logic                O,
   output logic                O2,
   input  logic                CE,
   input  logic                SR,
   lut_k_frac_cfg_if.slave     cfg
);
   localparam int TT       = 2**LUT_SIZE;
   localparam int N_CFG    = TT + 5;
   localparam int CW       = $clog2(N_CFG + 1);
   localparam int B_OUTREG = TT;
   localparam int B_CISEL  = TT + 1;
   localparam int B_FRAC   = TT + 2;
   localparam int B_CEUSE  = TT + 3;
   localparam int B_SRVAL  = TT + 4;
   localparam logic [CW-1:0] CNT_FULL = CW'(N_CFG);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [N_CFG-1:0]    sh, act;
   logic [TT-1:0]       tt;
   logic [CW-1:0]       cnt;
   logic                ff, done_q, err_q;
   logic                shift_en, commit, abort, fall, ff_upd;
   logic [LUT_SIZE-1:0] idx, idx_lo, idx_hi;
   logic                lut_o;

   assign tt = act[TT-1:0];

   // Control FSM next state plus the commit/abort/FF-update strobes.
   always_comb begin
      state_d  = IDLE;
      shift_en = cfg.MODE & cfg.CONFvalid;
      fall     = 1'b0;
      commit   = 1'b0;
      abort    = 1'b0;
      ff_upd   = 1'b0;
      if (cfg.MODE) state_d = SHIFT;
      case (state_q)
         IDLE:  ff_upd = ~cfg.MODE;
         SHIFT: begin
            if (!cfg.MODE) begin
               fall = 1'b1;
               if (cnt == CNT_FULL) commit = 1'b1;
               else                 abort  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Control state register (registered copy of MODE).
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Shadow shift register. Over-long frames pass through to the next BEL.
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn)         sh <= '0;
      else if (shift_en) sh <= {sh[N_CFG-2:0], cfg.CONFin};
   end

   // Bit counter. It saturates at a full frame and clears on every MODE fall.
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn)                             cnt <= '0;
      else if (fall)                         cnt <= '0;
      else if (shift_en && cnt != CNT_FULL)  cnt <= cnt + 1'b1;
   end

   // Active frame. It is loaded atomically from the shadow on a good commit.
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn)       act <= '0;
      else if (commit) act <= sh;
   end

   // Status flags: one-cycle done pulse and sticky short-frame error.
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= commit;
         if (commit)     err_q <= 1'b0;
         else if (abort) err_q <= 1'b1;
      end
   end

   // Output flip-flop. It is frozen during configuration and on the commit edge.
   always_ff @(posedge UserCLK or negedge RSTn) begin
      if (!RSTn) ff <= 1'b0;
      else if (ff_upd) begin
         if (SR)                         ff <= act[B_SRVAL];
         else if (!act[B_CEUSE] || CE)   ff <= lut_o;
      end
   end

   // LUT lookup. Fracture mode splits the table into two (K-1)-input halves.
   always_comb begin
      lut_o  = 1'b0;
      O2     = 1'b0;
      idx    = I;
      if (act[B_CISEL]) idx[0] = Ci;
      idx_lo = idx;
      idx_lo[LUT_SIZE-1] = 1'b0;
      idx_hi = idx;
      idx_hi[LUT_SIZE-1] = 1'b1;
      if (act[B_FRAC]) begin
         lut_o = tt[idx_lo];
         O2    = tt[idx_hi];
      end else begin
         lut_o = tt[idx];
      end
   end

   assign O             = act[B_OUTREG] ? ff : lut_o;
   assign Co            = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]);
   assign cfg.CONFout   = sh[N_CFG-1];
   assign cfg.CONFdone  = done_q;
   assign cfg.CONFerr   = err_q;
   assign cfg.cfg_state = logic'(state_q);
endmodule

// File: tb/tb_lut_k_frac_cfg.sv
// Bench for lut_k_frac_cfg (K=4). The driver pushes expected outputs into a
// queue. A negedge monitor pops them and compares them against the DUT.
module tb_lut_k_frac_cfg;
   localparam int N = 21;

   logic       UserCLK = 1'b0;
   logic       RSTn;
   logic [3:0] lut_i;
   logic       ci, ce, sr;
   logic       co, o, o2;
   int         checks = 0;
   int         errors = 0;

   lut_k_frac_cfg_if cfg_if();

   lut_k_frac_cfg #(.LUT_SIZE(4)) dut (
      .UserCLK(UserCLK), .RSTn(RSTn), .I(lut_i), .Ci(ci), .Co(co),
      .O(o), .O2(o2), .CE(ce), .SR(sr), .cfg(cfg_if)
   );

   // clock / watchdog
   always #5 UserCLK = ~UserCLK;
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (frame-level view) ----------------
   bit        m_q[$];      // shadow contents, oldest bit first
   int        m_cnt;
   bit        m_mode;
   bit [20:0] m_act;       // {sr_val, ce_use, frac, ci_sel, out_reg, tt[15:0]}
   bit        m_ff, m_done, m_err;

   function automatic void model_reset();
      m_q.delete();
      for (int k = 0; k < N; k++) m_q.push_back(1'b0);
      m_cnt = 0; m_mode = 0; m_act = '0; m_ff = 0; m_done = 0; m_err = 0;
   endfunction

   function automatic void lut_model(input logic [3:0] i, input bit c, output bit lo, output bit hi);
      int idx;
      idx = 8 * i[3] + 4 * i[2] + 2 * i[1] + (m_act[17] ? c : i[0]);
      if (m_act[18]) begin
         lo = m_act[idx % 8];
         hi = m_act[8 + idx % 8];
      end else begin
         lo = m_act[idx];
         hi = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      bit lo, hi;
      bit shift;
      shift = cfg_if.MODE && cfg_if.CONFvalid;
      lut_model(lut_i, ci, lo, hi);
      if (!cfg_if.MODE && !m_mode) begin
         if (sr)                   m_ff = m_act[20];
         else if (!m_act[19] || ce) m_ff = lo;
      end
      m_done = 0;
      if (m_mode && !cfg_if.MODE) begin
         if (m_cnt == N) begin
            for (int k = 0; k < N; k++) m_act[k] = m_q[N - 1 - k];
            m_err  = 0;
            m_done = 1;
         end else begin
            m_err = 1;
         end
         m_cnt = 0;
      end
      if (shift) begin
         m_q.push_back(cfg_if.CONFin);
         void'(m_q.pop_front());
         if (m_cnt < N) m_cnt++;
      end
      m_mode = cfg_if.MODE;
   endfunction

   // ---------------- scoreboard ----------------
   logic [3:0] exp_q[$];   // {kind[2:0], expected bit}

   function automatic string kind_name(input logic [2:0] k);
      case (k)
         3'd0: return "O";
         3'd1: return "O2";
         3'd2: return "Co";
         3'd3: return "CONFout";
         3'd4: return "CONFdone";
         default: return "CONFerr";
      endcase
   endfunction

   function automatic logic dut_val(input logic [2:0] k);
      case (k)
         3'd0: return o;
         3'd1: return o2;
         3'd2: return co;
         3'd3: return cfg_if.CONFout;
         3'd4: return cfg_if.CONFdone;
         default: return cfg_if.CONFerr;
      endcase
   endfunction

   task automatic compare(input string name, input logic got, input logic expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %b required %b (I=%h Ci=%b)", name, $time, got, expv, lut_i, ci);
      end
   endtask

   function automatic void push_all();
      bit lo, hi;
      int maj;
      lut_model(lut_i, ci, lo, hi);
      maj = int'(ci) + int'(lut_i[1]) + int'(lut_i[2]);
      exp_q.push_back({3'd0, m_act[16] ? m_ff : lo});
      exp_q.push_back({3'd1, hi});
      exp_q.push_back({3'd2, maj >= 2});
      exp_q.push_back({3'd3, m_q[0]});
      exp_q.push_back({3'd4, m_done});
      exp_q.push_back({3'd5, m_err});
   endfunction

   // monitor: checks every pending expectation at the falling edge
   always @(negedge UserCLK) begin
      logic [3:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare(kind_name(e[3:1]), dut_val(e[3:1]), e[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      push_all();
      model_edge();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic rand_user();
      lut_i = 4'($urandom);
      ci    = 1'($urandom);
      ce    = 1'($urandom);
      sr    = ($urandom_range(0, 3) == 0);
   endtask

   function automatic logic [20:0] mk(input bit srv, input bit ceu, input bit frac,
                                      input bit cis, input bit outr, input logic [15:0] t);
      return {srv, ceu, frac, cis, outr, t};
   endfunction

   // shifts the top nbits of w, MSB first, with random CONFvalid gaps
   task automatic send_bits(input logic [20:0] w, input int nbits);
      cfg_if.MODE = 1'b1;
      for (int b = 0; b < nbits; b++) begin
         while ($urandom_range(0, 3) == 0) begin
            cfg_if.CONFvalid = 1'b0;
            cfg_if.CONFin    = 1'($urandom);
            rand_user();
            step();
         end
         cfg_if.CONFvalid = 1'b1;
         cfg_if.CONFin    = w[20 - b];
         rand_user();
         step();
      end
      cfg_if.CONFvalid = 1'b0;
   endtask

   task automatic end_frame();
      cfg_if.MODE = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic sweep16();
      for (int k = 0; k < 16; k++) begin
         lut_i = 4'(k);
         ci    = 1'($urandom);
         step();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RSTn = 1'b0;
      lut_i = '0; ci = 0; ce = 0; sr = 0;
      cfg_if.MODE = 0; cfg_if.CONFin = 0; cfg_if.CONFvalid = 0;
      model_reset();
      @(posedge UserCLK); #1;
      push_all();
      @(posedge UserCLK); #1;
      RSTn = 1'b1;
      step();

      // AND4 load
      send_bits(mk(0, 0, 0, 0, 0, 16'h8000), N);
      end_frame();
      sweep16();

      // short frame over AND4, then a full frame clears the error
      send_bits(mk(0, 0, 0, 0, 0, 16'h0001), 10);
      end_frame();
      sweep16();
      send_bits(mk(0, 0, 0, 0, 0, 16'h8000), N);
      end_frame();
      lut_i = 4'hF; step();

      // registered mode: flush ff to 0 first
      lut_i = 4'h0; sr = 0; ce = 0; step(); step();
      send_bits(mk(1, 1, 0, 0, 1, 16'hFFFF), N);
      ce = 0; sr = 0;
      end_frame();
      step(); step();
      ce = 1; step(); step();
      send_bits(mk(1, 1, 0, 0, 1, 16'h0000), N);
      ce = 0; sr = 1;
      end_frame();
      step();
      sr = 0; ce = 1; step(); step();

      // fracture: XOR3 / XNOR3
      sr = 0;
      send_bits(mk(0, 0, 1, 0, 0, 16'h6996), N);
      end_frame();
      sweep16();

      // carry select and majority
      send_bits(mk(0, 0, 0, 1, 0, 16'($urandom)), N);
      end_frame();
      for (int k = 0; k < 8; k++) begin
         ci = k[2]; lut_i = {1'($urandom), k[1], k[0], 1'($urandom)};
         step();
      end
      sweep16();

      // pass-through: 42 bits
      send_bits(21'($urandom), N);
      send_bits(21'($urandom), N);
      end_frame();
      sweep16();

      // random frames, including short and over-length frames
      for (int f = 0; f < 8; f++) begin
         int nb;
         case ($urandom_range(0, 2))
            0: nb = N;
            1: nb = $urandom_range(1, N - 1);
            default: nb = $urandom_range(N + 1, 2 * N);
         endcase
         if (nb > N) send_bits(21'($urandom), nb - N);
         send_bits(21'($urandom), (nb > N) ? N : nb);
         end_frame();
         for (int c = 0; c < 20; c++) begin
            rand_user();
            step();
         end
      end

      // asynchronous reset in mid-cycle over a busy state
      sr = 0; ce = 0;
      send_bits(mk(0, 0, 0, 0, 0, 16'h8000), N);
      end_frame();
      send_bits(21'h1FFFFF, 5);
      lut_i = 4'hF;
      end_frame();
      @(negedge UserCLK); #2;
      RSTn = 1'b0;
      #1;
      compare("rst_O", o, 1'b0);
      compare("rst_O2", o2, 1'b0);
      compare("rst_CONFout", cfg_if.CONFout, 1'b0);
      compare("rst_CONFdone", cfg_if.CONFdone, 1'b0);
      compare("rst_CONFerr", cfg_if.CONFerr, 1'b0);
      model_reset();
      @(posedge UserCLK); #1;
      RSTn = 1'b1;
      step();
      cfg_if.MODE = 1'b1;
      step();
      end_frame();
      step();

      push_all();
      @(negedge UserCLK); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
